// File: rtl/mem_refill_arbiter_if.sv
// Bundle of cache-side and memory-side signals for mem_refill_arbiter.
//   slave  : arbiter view (takes requests and memory read data, drives acks,
//            refill lines, the memory request and busy)
//   master : surrounding-logic view (caches and memory model)
interface mem_refill_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [LINE_W-1:0] ic_rdata;
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0] dc_wdata;
  logic              dc_ack;
  logic [LINE_W-1:0] dc_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    output ic_ack, ic_rdata, dc_ack, dc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Shares one fixed-latency main-memory port between the icache (line reads)
// and the dcache (line reads and write-backs). Ties are resolved round-robin.
// The granted request is latched and held on the memory port for
// MEM_LATENCY cycles, then the owner gets a one-cycle ack with its line.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ic_*/dc_* cache handshakes, mem_* memory port, busy
module mem_refill_arbiter #(
  parameter int unsigned MEM_LATENCY = 10,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_refill_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  typedef enum logic {OWN_IC, OWN_DC} owner_e;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] ic_rdata_q;
  logic [LINE_W-1:0] dc_rdata_q;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              busy_q;

  logic              grant_valid_d;
  owner_e            grant_d;

  always_comb begin
    grant_valid_d = bus.ic_req | bus.dc_req;
    if (bus.ic_req && bus.dc_req) begin
      grant_d = (last_grant_q == OWN_DC) ? OWN_IC : OWN_DC;
    end else if (bus.ic_req) begin
      grant_d = OWN_IC;
    end else begin
      grant_d = OWN_DC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_DC;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_ack_q     <= 1'b0;
      dc_ack_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ic_ack_q <= 1'b0;
      dc_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d) begin
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= CNT_LOAD;
            mem_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ACCESS;
            if (grant_d == OWN_IC) begin
              addr_q   <= {bus.ic_addr[ADDR_W-1:4], 4'b0000};
              mem_we_q <= 1'b0;
            end else begin
              addr_q   <= {bus.dc_addr[ADDR_W-1:4], 4'b0000};
              mem_we_q <= bus.dc_we;
              wdata_q  <= bus.dc_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            // mem_we_q doubles as the latched transaction direction.
            if (!mem_we_q) begin
              if (owner_q == OWN_IC) ic_rdata_q <= bus.mem_rdata;
              else                   dc_rdata_q <= bus.mem_rdata;
            end
            ic_ack_q <= (owner_q == OWN_IC);
            dc_ack_q <= (owner_q == OWN_DC);
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ic_ack    = ic_ack_q;
  assign bus.dc_ack    = dc_ack_q;
  assign bus.ic_rdata  = ic_rdata_q;
  assign bus.dc_rdata  = dc_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_refill_arbiter.sv
module tb_mem_refill_arbiter;

  localparam int unsigned L = 10;
  localparam logic [127:0] GARBAGE = {4{32'hDEADBEEF}};

  typedef struct {
    bit           is_dc;
    bit           we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int unsigned  ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  exp_t q[$];
  exp_t q2[$];

  mem_refill_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();
  mem_refill_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus2 ();

  mem_refill_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .LINE_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mem_refill_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .LINE_W(128)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: line data is only valid in the last of L stable cycles.
  function automatic logic [127:0] model(input logic [31:0] a);
    if (a == 32'h0000_0100) return {32{4'hA}};
    return {a, ~a, a, ~a};
  endfunction

  int unsigned en_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else if (bus.mem_en) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end
  assign bus.mem_rdata  = (bus.mem_en && en_cnt == L - 1) ? model(bus.mem_addr) : GARBAGE;
  assign bus2.mem_rdata = bus2.mem_en ? model(bus2.mem_addr) : GARBAGE;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input bit is_dc, input bit we, input logic [31:0] addr,
                      input logic [127:0] wdata, input logic [127:0] rdata,
                      input int unsigned ack_cyc);
    exp_t e;
    e.is_dc = is_dc; e.we = we; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.ack_cyc = ack_cyc;
    q.push_back(e);
  endtask

  // Wait (bounded) for the ack of one port, then drop its req after that edge.
  // which: 0 = ic, 1 = dc, 2 = dc on the MEM_LATENCY=1 instance.
  task automatic serve(input int which);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (which == 0) seen = bus.ic_ack;
      else if (which == 1) seen = bus.dc_ack;
      else seen = bus2.dc_ack;
    end
    if (!seen) check_eq("ack_timeout", 128'(which), 128'hFF);
    @(posedge clk); #1;
    if (which == 0) bus.ic_req = 1'b0;
    else if (which == 1) bus.dc_req = 1'b0;
    else bus2.dc_req = 1'b0;
  endtask

  // Scoreboard monitor for the MEM_LATENCY=L instance.
  initial begin : mon
    int unsigned en_cycles = 0;
    int unsigned acc_bad = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cycles = 0;
        acc_bad = 0;
      end else begin
        if (bus.mem_en) begin
          en_cycles++;
          if (q.size() == 0) acc_bad++;
          else if (bus.mem_addr !== q[0].addr || bus.mem_we !== q[0].we ||
                   (q[0].we && bus.mem_wdata !== q[0].wdata) || !bus.busy) acc_bad++;
        end
        if (bus.ic_ack || bus.dc_ack) begin
          if (q.size() == 0) begin
            check_eq("spurious_ack", {bus.ic_ack, bus.dc_ack}, 2'b00);
          end else begin
            e = q.pop_front();
            check_eq("ack_port", {bus.ic_ack, bus.dc_ack}, e.is_dc ? 2'b01 : 2'b10);
            check_eq("ack_cycle", cyc, e.ack_cyc);
            check_eq("ack_rdata", e.is_dc ? bus.dc_rdata : bus.ic_rdata, e.rdata);
            check_eq("access_len", en_cycles, L);
            check_eq("access_bus_bad", acc_bad, 0);
            check_eq("resp_busy_en", {bus.busy, bus.mem_en, bus.mem_we}, 3'b100);
          end
          en_cycles = 0;
          acc_bad = 0;
        end
      end
    end
  end

  // Scoreboard monitor for the MEM_LATENCY=1 instance.
  initial begin : mon2
    int unsigned en2 = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) en2 = 0;
      else begin
        if (bus2.mem_en) en2++;
        if (bus2.ic_ack || bus2.dc_ack) begin
          if (q2.size() == 0) begin
            check_eq("lat1_spurious_ack", {bus2.ic_ack, bus2.dc_ack}, 2'b00);
          end else begin
            e = q2.pop_front();
            check_eq("lat1_ack_port", {bus2.ic_ack, bus2.dc_ack}, 2'b01);
            check_eq("lat1_ack_cycle", cyc, e.ack_cyc);
            check_eq("lat1_rdata", bus2.dc_rdata, e.rdata);
            check_eq("lat1_access_len", en2, 1);
          end
          en2 = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int unsigned s;
    exp_t e2;
    bus.ic_req = 0; bus.ic_addr = '0; bus.dc_req = 0; bus.dc_we = 0;
    bus.dc_addr = '0; bus.dc_wdata = '0;
    bus2.ic_req = 0; bus2.ic_addr = '0; bus2.dc_req = 0; bus2.dc_we = 0;
    bus2.dc_addr = '0; bus2.dc_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {bus.ic_ack, bus.dc_ack, bus.mem_en, bus.mem_we, bus.busy}, 5'b0);
    check_eq("rst_ic_rdata", bus.ic_rdata, 128'h0);
    check_eq("rst_dc_rdata", bus.dc_rdata, 128'h0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone icache read.
    bus.ic_req = 1; bus.ic_addr = 32'h0000_0104;
    push(0, 0, 32'h0000_0100, '0, {32{4'hA}}, cyc + L + 1);
    serve(0);

    // dcache write-back; dc_rdata must stay at its reset value.
    bus.dc_req = 1; bus.dc_we = 1; bus.dc_addr = 32'h0000_2008;
    bus.dc_wdata = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    push(1, 1, 32'h0000_2000, 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978, 128'h0, cyc + L + 1);
    serve(1);
    bus.dc_we = 0;

    // Reset, then two back-to-back ties: IC, DC, IC, DC.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    s = cyc;
    bus.ic_req = 1; bus.ic_addr = 32'h0000_030C;
    bus.dc_req = 1; bus.dc_addr = 32'h0000_4004;
    push(0, 0, 32'h0000_0300, '0, 128'h00000300_FFFFFCFF_00000300_FFFFFCFF, s + L + 1);
    push(1, 0, 32'h0000_4000, '0, 128'h00004000_FFFFBFFF_00004000_FFFFBFFF, s + 2*L + 3);
    fork
      serve(0);
      serve(1);
    join
    s = cyc;
    bus.ic_req = 1; bus.ic_addr = 32'h0000_050F;
    bus.dc_req = 1; bus.dc_addr = 32'h0000_6001;
    push(0, 0, 32'h0000_0500, '0, 128'h00000500_FFFFFAFF_00000500_FFFFFAFF, s + L + 1);
    push(1, 0, 32'h0000_6000, '0, 128'h00006000_FFFF9FFF_00006000_FFFF9FFF, s + 2*L + 3);
    fork
      serve(0);
      serve(1);
    join

    // Reset in ACCESS cycle 5, req held; restart with full latency.
    s = cyc;
    bus.ic_req = 1; bus.ic_addr = 32'h0000_0700;
    push(0, 0, 32'h0000_0700, '0, 128'h00000700_FFFFF8FF_00000700_FFFFF8FF, s + L + 1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check_eq("midrst_ctrl", {bus.ic_ack, bus.dc_ack, bus.mem_en, bus.mem_we, bus.busy}, 5'b0);
    check_eq("midrst_ic_rdata", bus.ic_rdata, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, 0, 32'h0000_0700, '0, 128'h00000700_FFFFF8FF_00000700_FFFFF8FF, cyc + L + 1);
    serve(0);

    // ic_req dropped in ACCESS cycle 3; ack still arrives on schedule.
    s = cyc;
    bus.ic_req = 1; bus.ic_addr = 32'h0000_0800;
    push(0, 0, 32'h0000_0800, '0, 128'h00000800_FFFFF7FF_00000800_FFFFF7FF, s + L + 1);
    repeat (3) @(posedge clk);
    #1;
    bus.ic_req = 0;
    serve(0);
    repeat (5) @(negedge clk);
    check_eq("drop_idle", {bus.busy, bus.mem_en}, 2'b00);

    // MEM_LATENCY=1 instance: dc read acked two cycles after the request.
    bus2.dc_req = 1; bus2.dc_we = 0; bus2.dc_addr = 32'h0000_901C;
    e2.is_dc = 1; e2.we = 0; e2.addr = 32'h0000_9010; e2.wdata = '0;
    e2.rdata = 128'h00009010_FFFF6FEF_00009010_FFFF6FEF; e2.ack_cyc = cyc + 2;
    q2.push_back(e2);
    serve(2);

    repeat (4) @(negedge clk);
    check_eq("sb_empty", q.size(), 0);
    check_eq("sb2_empty", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
